// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request bus, the branch redirect inputs and the
// instruction output handshake between the fetch stage and its neighbours.
`timescale 1ns/1ps
interface fetch_unit_if #(
    parameter int word_size  = 32,
    parameter int addr_width = 8
);
    logic                  imem_req;
    logic [addr_width-1:0] imem_addr;
    logic                  imem_ack;
    logic [word_size-1:0]  imem_rdata;
    logic                  branch_taken;
    logic [addr_width-1:0] branch_target;
    logic [word_size-1:0]  instr_out;
    logic [addr_width-1:0] pc_out;
    logic                  instr_valid;
    logic                  instr_ready;

    modport master (
        output imem_req, imem_addr, instr_out, pc_out, instr_valid,
        input  imem_ack, imem_rdata, branch_taken, branch_target, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, pc_out, instr_valid,
        output imem_ack, imem_rdata, branch_taken, branch_target, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding req/ack fetch, 2-entry prefetch
// FIFO presented over valid/ready, and branch redirect with drain of a pending fetch.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int                    word_size  = 32,
    parameter int                    addr_width = 8,
    parameter logic [addr_width-1:0] reset_pc   = {addr_width{1'b0}},
    parameter int                    fifo_depth = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam logic [addr_width-1:0] addr_one = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [1:0]            depth_c  = 2'(fifo_depth);

    state_e                state_r, state_s;
    logic                  req_r, req_s;
    logic [addr_width-1:0] addr_r, addr_s;
    logic [addr_width-1:0] target_r, target_s;

    // FIFO slot 0 is always the head, so the output ports come straight off registers.
    logic                  v0_r, v0_s, v1_r, v1_s;
    logic [word_size-1:0]  d0_r, d0_s, d1_r, d1_s;
    logic [addr_width-1:0] p0_r, p0_s, p1_r, p1_s;

    logic                  pop_s;
    logic                  push_s;
    logic [1:0]            occ_s;
    logic                  space_s;

    // Next-state logic for the FIFO, the request register and the RUN/DRAIN FSM.
    always_comb begin
        state_s  = state_r;
        req_s    = req_r;
        addr_s   = addr_r;
        target_s = target_r;
        v0_s     = v0_r;
        v1_s     = v1_r;
        d0_s     = d0_r;
        d1_s     = d1_r;
        p0_s     = p0_r;
        p1_s     = p1_r;

        pop_s  = v0_r & bus.instr_ready;
        push_s = (state_r == RUN) & req_r & bus.imem_ack & ~bus.branch_taken;

        if (bus.branch_taken) begin
            v0_s = 1'b0;
            v1_s = 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (v1_r) begin
                        d0_s = d1_r;
                        p0_s = p1_r;
                        d1_s = bus.imem_rdata;
                        p1_s = addr_r;
                    end else begin
                        d0_s = bus.imem_rdata;
                        p0_s = addr_r;
                    end
                end
                2'b10: begin
                    if (v0_r) begin
                        d1_s = bus.imem_rdata;
                        p1_s = addr_r;
                        v1_s = 1'b1;
                    end else begin
                        d0_s = bus.imem_rdata;
                        p0_s = addr_r;
                        v0_s = 1'b1;
                    end
                end
                2'b01: begin
                    d0_s = d1_r;
                    p0_s = p1_r;
                    v0_s = v1_r;
                    v1_s = 1'b0;
                end
                default: begin
                    v0_s = v0_r;
                    v1_s = v1_r;
                end
            endcase
        end

        // Issue only if the post-push/pop occupancy leaves room for the coming ack.
        occ_s   = {1'b0, v0_s} + {1'b0, v1_s};
        space_s = (occ_s < depth_c);

        case (state_r)
            RUN: begin
                if (bus.branch_taken) begin
                    target_s = bus.branch_target;
                    if (req_r & ~bus.imem_ack) begin
                        state_s = DRAIN;
                    end else begin
                        req_s  = 1'b1;
                        addr_s = bus.branch_target;
                    end
                end else if (req_r & bus.imem_ack) begin
                    addr_s = addr_r + addr_one;
                    req_s  = space_s;
                end else if (~req_r) begin
                    req_s = space_s;
                end else begin
                    req_s = 1'b1;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    state_s  = RUN;
                    req_s    = 1'b1;
                    addr_s   = bus.branch_taken ? bus.branch_target : target_r;
                    target_s = addr_s;
                end else if (bus.branch_taken) begin
                    target_s = bus.branch_target;
                end else begin
                    target_s = target_r;
                end
            end
            default: begin
                state_s = RUN;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            req_r    <= 1'b0;
            addr_r   <= reset_pc;
            target_r <= reset_pc;
            v0_r     <= 1'b0;
            v1_r     <= 1'b0;
            d0_r     <= {word_size{1'b0}};
            d1_r     <= {word_size{1'b0}};
            p0_r     <= {addr_width{1'b0}};
            p1_r     <= {addr_width{1'b0}};
        end else begin
            state_r  <= state_s;
            req_r    <= req_s;
            addr_r   <= addr_s;
            target_r <= target_s;
            v0_r     <= v0_s;
            v1_r     <= v1_s;
            d0_r     <= d0_s;
            d1_r     <= d1_s;
            p0_r     <= p0_s;
            p1_r     <= p1_s;
        end
    end

    assign bus.imem_req    = req_r;
    assign bus.imem_addr   = addr_r;
    assign bus.instr_valid = v0_r;
    assign bus.instr_out   = d0_r;
    assign bus.pc_out      = p0_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus a PC wrap sequence on a second
// instance reset to 0xFE.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;

    always #5 clk = ~clk;

    fetch_unit_if #(.word_size(32), .addr_width(8)) bus ();
    fetch_unit_if #(.word_size(32), .addr_width(8)) wbus ();

    fetch_unit #(.word_size(32), .addr_width(8), .reset_pc(8'h00), .fifo_depth(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.word_size(32), .addr_width(8), .reset_pc(8'hFE), .fifo_depth(2)) dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (wbus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       chk;
        logic       rst;
        logic       ack;
        logic [7:0] da;
        logic       br;
        logic [7:0] tgt;
        logic       rdy;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word_at(input logic [7:0] a);
        return 32'h9800_0200 + {24'h000000, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic chk, input logic r, input logic ack, input logic [7:0] da,
                       input logic br, input logic [7:0] tgt, input logic rdy,
                       input logic e_req, input logic [7:0] e_addr,
                       input logic e_valid, input logic [7:0] e_pc);
        vec_t v;
        v.chk = chk; v.rst = r; v.ack = ack; v.da = da; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] wa [4];
        rst = 1'b1;
        rst_w = 1'b1;
        bus.imem_ack = 1'b0;      bus.imem_rdata = 32'h0;
        bus.branch_taken = 1'b0;  bus.branch_target = 8'h00;
        bus.instr_ready = 1'b0;
        wbus.imem_ack = 1'b0;     wbus.imem_rdata = 32'h0;
        wbus.branch_taken = 1'b0; wbus.branch_target = 8'h00;
        wbus.instr_ready = 1'b0;

        // chk rst ack data br tgt rdy | req addr valid pc
        add(1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00);
        add(1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h01,1'b0,8'h00,1'b1, 1'b1,8'h01,1'b1,8'h00);
        add(1'b1,1'b0,1'b1,8'h02,1'b0,8'h00,1'b1, 1'b1,8'h02,1'b1,8'h01);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h03,1'b1,8'h02);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h03,1'b0,8'h00);
        // ready low, memory always acking: fill to two entries then stop requesting
        add(1'b1,1'b0,1'b1,8'h03,1'b0,8'h00,1'b0, 1'b1,8'h03,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h04,1'b0,8'h00,1'b0, 1'b1,8'h04,1'b1,8'h03);
        add(1'b1,1'b0,1'b1,8'h05,1'b0,8'h00,1'b0, 1'b0,8'h05,1'b1,8'h03);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b0,8'h05,1'b1,8'h03);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h05,1'b1,8'h04);
        // slow memory: request held stable across wait cycles
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b1,8'h05,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b1,8'h05,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b1,8'h05,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h05,1'b0,8'h00,1'b0, 1'b1,8'h05,1'b0,8'h00);
        // branch while addr 6 pending: flush, drain, refetch from 0x40
        add(1'b1,1'b0,1'b0,8'h00,1'b1,8'h40,1'b0, 1'b1,8'h06,1'b1,8'h05);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h06,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h06,1'b0,8'h00,1'b1, 1'b1,8'h06,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h40,1'b0,8'h00,1'b1, 1'b1,8'h40,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h41,1'b1,8'h40);
        add(1'b1,1'b0,1'b1,8'h41,1'b0,8'h00,1'b1, 1'b1,8'h41,1'b0,8'h00);
        // branch together with ack of 0x42 and pop of 0x41: 0x42 is dropped
        add(1'b1,1'b0,1'b1,8'h42,1'b1,8'h10,1'b1, 1'b1,8'h42,1'b1,8'h41);
        add(1'b1,1'b0,1'b1,8'h10,1'b0,8'h00,1'b1, 1'b1,8'h10,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h11,1'b0,8'h00,1'b0, 1'b1,8'h11,1'b1,8'h10);
        // reset mid-stream with a full FIFO, then with a pending request
        add(1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h12,1'b1,8'h10);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00);
        add(1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b1,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0,8'h00);
        // two redirects during DRAIN: the later target wins
        add(1'b1,1'b0,1'b0,8'h00,1'b1,8'h20,1'b0, 1'b1,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b1,8'h30,1'b0, 1'b1,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h00,1'b0,8'h00);
        add(1'b1,1'b0,1'b1,8'h30,1'b0,8'h00,1'b1, 1'b1,8'h30,1'b0,8'h00);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h31,1'b1,8'h30);
        add(1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1, 1'b1,8'h31,1'b0,8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            rst                = v.rst;
            bus.imem_ack       = v.ack;
            bus.imem_rdata     = word_at(v.da);
            bus.branch_taken   = v.br;
            bus.branch_target  = v.tgt;
            bus.instr_ready    = v.rdy;
            if (v.chk) begin
                check($sformatf("v%0d_req", i),   32'(bus.imem_req),    32'(v.e_req));
                check($sformatf("v%0d_addr", i),  32'(bus.imem_addr),   32'(v.e_addr));
                check($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(v.e_valid));
                if (v.e_valid) begin
                    check($sformatf("v%0d_pc", i),    32'(bus.pc_out), 32'(v.e_pc));
                    check($sformatf("v%0d_instr", i), bus.instr_out,   word_at(v.e_pc));
                end
            end
        end

        // Second instance: reset values, then fetch across the address wrap.
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        check("wrap_rst_req",   32'(wbus.imem_req),    32'd0);
        check("wrap_rst_addr",  32'(wbus.imem_addr),   32'h0000_00FE);
        check("wrap_rst_valid", 32'(wbus.instr_valid), 32'd0);
        check("wrap_rst_instr", wbus.instr_out,        32'h0000_0000);
        check("wrap_rst_pc",    32'(wbus.pc_out),      32'd0);
        rst_w = 1'b0;
        wbus.imem_ack = 1'b1;
        wbus.instr_ready = 1'b1;
        wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wbus.imem_rdata = word_at(wa[k]);
            check($sformatf("wrap%0d_req", k),  32'(wbus.imem_req),  32'd1);
            check($sformatf("wrap%0d_addr", k), 32'(wbus.imem_addr), 32'(wa[k]));
            if (k == 0) begin
                check("wrap0_valid", 32'(wbus.instr_valid), 32'd0);
            end else begin
                check($sformatf("wrap%0d_valid", k), 32'(wbus.instr_valid), 32'd1);
                check($sformatf("wrap%0d_pc", k),    32'(wbus.pc_out),      32'(wa[k-1]));
                check($sformatf("wrap%0d_instr", k), wbus.instr_out,        word_at(wa[k-1]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
